// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_WB_MEM = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_BRANCH = 4'd8,
        S_EXEC_I = 4'd9,
        S_WB_I   = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUSEL_FUNCT = 3'b000;
    localparam logic [2:0] ALUSEL_ADD   = 3'b001;
    localparam logic [2:0] ALUSEL_SUB   = 3'b010;
    localparam logic [2:0] ALUSEL_AND   = 3'b011;
    localparam logic [2:0] ALUSEL_OR    = 3'b100;
    localparam logic [2:0] ALUSEL_SLT   = 3'b101;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake and are guarded by the watchdog.
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller-to-datapath bundle: IR opcode and memory ready in, strobes out.
// Wires only; zero latency.
// mem_ready is the only handshake; the controller holds its state until it rises.
interface mc_main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       imm_zext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_sel;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, imm_zext, alu_src_a, alu_src_b,
               pc_source, alu_sel, illegal_op, bus_error
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, imm_zext, alu_src_a, alu_src_b,
               pc_source, alu_sel, illegal_op, bus_error
    );
endinterface

// File: rtl/mc_mem_wait.sv
// Memory wait watchdog: counts stalled cycles and flags a timeout.
// timeout is combinational in the cycle the count would reach MEM_WAIT_MAX.
// Counting pauses when stall is low; a ready in the final cycle beats the timeout.
module mc_mem_wait #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic stall,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // The stalled cycle that would bring the count to MEM_WAIT_MAX is the last one allowed.
    assign timeout = stall && (cnt_q == WAIT_W'(MEM_WAIT_MAX - 1));

    // Next count: restart on a new wait state or after a timeout, else count stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || timeout) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM driving datapath strobes and alu_sel.
// Moore outputs from the current state; ir_write/pc_write in FETCH follow mem_ready.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready, abandoning to FETCH on watchdog timeout.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_main_ctrl_if.master      bus,
    output logic [3:0]          state_o
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   bus_err_q;
    logic   zext_q;
    logic   exec_zext;
    logic   timeout;
    logic   stall;

    assign stall     = is_wait_state(state_q) && !bus.mem_ready;
    assign exec_zext = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);

    mc_mem_wait #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .WAIT_W       (WAIT_W)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state_q),
        .stall   (stall),
        .timeout (timeout)
    );

    // Next-state decode; opcode is only consulted in DECODE and MEMADR here.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout)   state_d = S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                         state_d = S_EXEC_R;
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_J:                             state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  state_d = S_WB_MEM;
                else if (timeout)   state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (bus.mem_ready || timeout) state_d = S_FETCH;
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register plus the registered error pulses and the held zero-extend select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            zext_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= timeout;
            if (state_q == S_EXEC_I) zext_q <= exec_zext;
        end
    end

    logic       pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
    logic       ir_write_raw, reg_write_raw;
    logic       iord, mem_to_reg, reg_dst, imm_zext, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_sel;

    // Moore output decode; the write/request strobes are masked by reset below.
    always_comb begin
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        iord              = 1'b0;
        mem_to_reg        = 1'b0;
        reg_dst           = 1'b0;
        imm_zext          = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRCB_B;
        pc_source         = PCSRC_ALU;
        alu_sel           = ALUSEL_FUNCT;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                alu_sel      = ALUSEL_ADD;
                ir_write_raw = bus.mem_ready;
                pc_write_raw = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_sel   = ALUSEL_ADD;
            end
            S_EXEC_R: alu_src_a = 1'b1;
            S_WB_R: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_sel   = ALUSEL_ADD;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a         = 1'b1;
                alu_sel           = ALUSEL_SUB;
                pc_write_cond_raw = 1'b1;
                pc_source         = PCSRC_ALUOUT;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                imm_zext  = exec_zext;
                case (bus.opcode)
                    OP_ANDI: alu_sel = ALUSEL_AND;
                    OP_ORI:  alu_sel = ALUSEL_OR;
                    OP_SLTI: alu_sel = ALUSEL_SLT;
                    default: alu_sel = ALUSEL_ADD;
                endcase
            end
            S_WB_I: begin
                reg_write_raw = 1'b1;
                imm_zext      = zext_q;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_source    = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.pc_write      = pc_write_raw      && rst_n;
    assign bus.pc_write_cond = pc_write_cond_raw && rst_n;
    assign bus.mem_read      = mem_read_raw      && rst_n;
    assign bus.mem_write     = mem_write_raw     && rst_n;
    assign bus.ir_write      = ir_write_raw      && rst_n;
    assign bus.reg_write     = reg_write_raw     && rst_n;
    assign bus.iord          = iord;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.imm_zext      = imm_zext;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.pc_source     = pc_source;
    assign bus.alu_sel       = alu_sel;
    assign bus.illegal_op    = illegal_q;
    assign bus.bus_error     = bus_err_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench: an instruction-level planner pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
// Directed cases first, then randomized instruction streams with waits and resets.
module tb_mc_main_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state_o;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       imm_zext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_sel;
        logic       illegal_op;
        logic       bus_error;
    } obs_t;

    typedef struct {
        obs_t  e;
        string tag;
    } sb_t;

    typedef struct {
        state_t st;
        bit     rdy;
        bit     ill_next;
        bit     bus_next;
    } cyc_t;

    sb_t  sb_q[$];
    cyc_t plan_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend_ill = 0;
    bit   pend_bus = 0;
    bit   rand_rdy = 0;
    obs_t act;

    always_comb begin
        act.st            = state_o;
        act.pc_write      = bus.pc_write;
        act.pc_write_cond = bus.pc_write_cond;
        act.iord          = bus.iord;
        act.mem_read      = bus.mem_read;
        act.mem_write     = bus.mem_write;
        act.ir_write      = bus.ir_write;
        act.mem_to_reg    = bus.mem_to_reg;
        act.reg_dst       = bus.reg_dst;
        act.reg_write     = bus.reg_write;
        act.imm_zext      = bus.imm_zext;
        act.alu_src_a     = bus.alu_src_a;
        act.alu_src_b     = bus.alu_src_b;
        act.pc_source     = bus.pc_source;
        act.alu_sel       = bus.alu_sel;
        act.illegal_op    = bus.illegal_op;
        act.bus_error     = bus.bus_error;
    end

    // Expected datapath controls for one step of an instruction.
    function automatic obs_t ref_out(state_t st, bit rdy, logic [5:0] op, bit in_rst);
        obs_t o;
        bit   zx;
        o    = '0;
        o.st = st;
        zx   = (op == 6'b001100) || (op == 6'b001101);
        case (st)
            S_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_sel = 3'b001;
                            o.ir_write = rdy; o.pc_write = rdy; end
            S_DECODE: begin o.alu_src_b = 2'b11; o.alu_sel = 3'b001; end
            S_EXEC_R: begin o.alu_src_a = 1; end
            S_WB_R:   begin o.reg_write = 1; o.reg_dst = 1; end
            S_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_sel = 3'b001; end
            S_MEMRD:  begin o.mem_read = 1; o.iord = 1; end
            S_MEMWR:  begin o.mem_write = 1; o.iord = 1; end
            S_WB_MEM: begin o.reg_write = 1; o.mem_to_reg = 1; end
            S_BRANCH: begin o.alu_src_a = 1; o.alu_sel = 3'b010; o.pc_write_cond = 1;
                            o.pc_source = 2'b01; end
            S_EXEC_I: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10; o.imm_zext = zx;
                if (op == 6'b001000)      o.alu_sel = 3'b001;
                else if (op == 6'b001100) o.alu_sel = 3'b011;
                else if (op == 6'b001101) o.alu_sel = 3'b100;
                else                      o.alu_sel = 3'b101;
            end
            S_WB_I:   begin o.reg_write = 1; o.imm_zext = zx; end
            S_JUMP:   begin o.pc_write = 1; o.pc_source = 2'b10; end
            default: ;
        endcase
        if (in_rst) begin
            o.pc_write = 0; o.pc_write_cond = 0; o.mem_read = 0;
            o.mem_write = 0; o.ir_write = 0; o.reg_write = 0;
        end
        return o;
    endfunction

    function automatic void push_step(state_t st, bit ill);
        cyc_t c;
        c.st = st; c.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        c.ill_next = ill; c.bus_next = 0;
        plan_q.push_back(c);
    endfunction

    // Memory-waiting step: w cycles without ready, then completion, or 15 idle cycles then timeout.
    function automatic bit add_wait(state_t st, int w);
        cyc_t c;
        int   n;
        n = (w >= 15) ? 15 : w;
        for (int i = 0; i < n; i++) begin
            c.st = st; c.rdy = 0; c.ill_next = 0; c.bus_next = (w >= 15) && (i == n - 1);
            plan_q.push_back(c);
        end
        if (w >= 15) return 1'b0;
        c.st = st; c.rdy = 1; c.ill_next = 0; c.bus_next = 0;
        plan_q.push_back(c);
        return 1'b1;
    endfunction

    // Plans one instruction as a list of steps, then drives it cycle by cycle.
    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input int abort_at, input string tag);
        obs_t e;
        sb_t  s;
        plan_q.delete();
        if (add_wait(S_FETCH, fwait)) begin
            case (op)
                6'b000000: begin push_step(S_DECODE, 0); push_step(S_EXEC_R, 0); push_step(S_WB_R, 0); end
                6'b100011: begin push_step(S_DECODE, 0); push_step(S_MEMADR, 0);
                                 if (add_wait(S_MEMRD, mwait)) push_step(S_WB_MEM, 0); end
                6'b101011: begin push_step(S_DECODE, 0); push_step(S_MEMADR, 0);
                                 void'(add_wait(S_MEMWR, mwait)); end
                6'b000100: begin push_step(S_DECODE, 0); push_step(S_BRANCH, 0); end
                6'b001000, 6'b001100, 6'b001101, 6'b001010:
                           begin push_step(S_DECODE, 0); push_step(S_EXEC_I, 0); push_step(S_WB_I, 0); end
                6'b000010: begin push_step(S_DECODE, 0); push_step(S_JUMP, 0); end
                default:   push_step(S_DECODE, 1);
            endcase
        end
        for (int i = 0; i < plan_q.size(); i++) begin
            @(posedge clk);
            #1;
            bus.opcode    = op;
            bus.mem_ready = plan_q[i].rdy;
            rst_n         = (i != abort_at);
            e = ref_out(plan_q[i].st, plan_q[i].rdy, op, i == abort_at);
            e.illegal_op = pend_ill;
            e.bus_error  = pend_bus;
            s.e = e; s.tag = tag;
            sb_q.push_back(s);
            if (i == abort_at) begin
                pend_ill = 0; pend_bus = 0;
                break;
            end
            pend_ill = plan_q[i].ill_next;
            pend_bus = plan_q[i].bus_next;
        end
    endtask

    // Monitor: compares whatever the stimulus side expects for this cycle.
    initial begin
        sb_t s;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                s = sb_q.pop_front();
                checks++;
                if (act !== s.e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", s.tag, act, s.e, $time);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [9];
        logic [5:0] op;
        int fw, mw, ab;
        sb_t s;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b001100;
        ops[6] = 6'b001101; ops[7] = 6'b001010; ops[8] = 6'b000010;

        rst_n = 0; bus.mem_ready = 1; bus.opcode = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            s.e = ref_out(S_FETCH, 1, 6'b000000, 1); s.tag = "reset";
            sb_q.push_back(s);
        end

        rand_rdy = 0;
        run_instr(6'b000000, 0, 0, -1, "rtype");
        run_instr(6'b100011, 0, 3, -1, "lw_wait3");
        run_instr(6'b101011, 0, 0, -1, "sw");
        run_instr(6'b000100, 0, 0, -1, "beq");
        run_instr(6'b001101, 0, 0, -1, "ori");
        run_instr(6'b001100, 0, 0, -1, "andi");
        run_instr(6'b001010, 0, 0, -1, "slti");
        run_instr(6'b001000, 0, 0, -1, "addi");
        run_instr(6'b000010, 0, 0, -1, "j");
        run_instr(6'b111111, 0, 0, -1, "illegal");
        run_instr(6'b000000, 15, 0, -1, "fetch_timeout");
        run_instr(6'b000000, 14, 0, -1, "fetch_ready_at_15");
        run_instr(6'b100011, 0, 15, -1, "lw_timeout");
        run_instr(6'b101011, 0, 14, -1, "sw_ready_at_15");
        run_instr(6'b101011, 0, 0, 3, "sw_reset_in_memwr");
        run_instr(6'b100011, 0, 0, 4, "lw_reset_in_wbmem");
        run_instr(6'b000010, 0, 0, 2, "j_reset_in_jump");

        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, fw, mw, ab, "random");
        end
        run_instr(6'b000000, 0, 0, -1, "tail");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
